// File: rtl/quadrant_pkg.sv
// Shared definitions for the quadrant selector front end and the quadrant highlighter.
// Quadrant codes, FSM state type.
package quadrant_pkg;

  localparam logic [2:0] Q_NONE = 3'b000;
  localparam logic [2:0] Q_TL   = 3'b001;
  localparam logic [2:0] Q_TR   = 3'b010;
  localparam logic [2:0] Q_BL   = 3'b011;
  localparam logic [2:0] Q_BR   = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NAV  = 2'd1,
    S_WIN  = 2'd2,
    S_LOSE = 2'd3
  } qsel_state_t;

endpackage

// File: rtl/quadrant_selector_if.sv
// Signal bundle between the game controller / board buttons and quadrant_selector.
// Handshake: there is no valid/ready pair here. Buttons are raw asynchronous
// levels, start is a single-cycle strobe that is always accepted on the clock
// edge where it is high, and the outputs are registered levels with no ready.
interface quadrant_selector_if #(
  parameter int SEQ_LEN = 4
);
  import quadrant_pkg::*;

  logic                   btn_up;
  logic                   btn_down;
  logic                   btn_left;
  logic                   btn_right;
  logic                   btn_sel;
  logic                   start;
  logic [3*SEQ_LEN-1:0]   target_seq;
  logic [2:0]             cuadrante;
  logic                   win;
  logic                   lose;
  logic [2:0]             seq_idx;
  qsel_state_t            state_dbg;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_sel, start, target_seq,
    input  cuadrante, win, lose, seq_idx, state_dbg
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_sel, start, target_seq,
    output cuadrante, win, lose, seq_idx, state_dbg
  );

endinterface

// File: rtl/button_debouncer.sv
// One raw push button: 2-flop synchroniser, stability counter, and a
// one-cycle press pulse on the debounced 0->1 transition (releases are silent).
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Synchronise, then accept a new level only after it has differed from the
  // current one for DEBOUNCE_CYCLES consecutive clocks; any bounce restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        level <= sync2;
        press <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/quadrant_selector.sv
// Button-driven quadrant selection and sequence-matching game FSM.
// Build option: define QSEL_WRAP_NAV_EN to make navigation wrap within a row
// or column instead of saturating at the grid edge.
module quadrant_selector
  import quadrant_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SEQ_LEN         = 4
) (
  input logic                clk,
  input logic                rst,
  quadrant_selector_if.slave bus
);

`ifdef QSEL_WRAP_NAV_EN
  localparam bit WRAP_NAV = 1'b1;
`else
  localparam bit WRAP_NAV = 1'b0;
`endif

  logic p_up, p_down, p_left, p_right, p_sel;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up    (.clk(clk), .rst(rst), .btn(bus.btn_up),    .press(p_up));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down  (.clk(clk), .rst(rst), .btn(bus.btn_down),  .press(p_down));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left  (.clk(clk), .rst(rst), .btn(bus.btn_left),  .press(p_left));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (.clk(clk), .rst(rst), .btn(bus.btn_right), .press(p_right));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel   (.clk(clk), .rst(rst), .btn(bus.btn_sel),   .press(p_sel));

  function automatic logic [2:0] nav_up(input logic [2:0] q);
    nav_up = q;
    case (q)
      Q_BL: nav_up = Q_TL;
      Q_BR: nav_up = Q_TR;
      Q_TL: if (WRAP_NAV) nav_up = Q_BL;
      Q_TR: if (WRAP_NAV) nav_up = Q_BR;
      default: ;
    endcase
  endfunction

  function automatic logic [2:0] nav_down(input logic [2:0] q);
    nav_down = q;
    case (q)
      Q_TL: nav_down = Q_BL;
      Q_TR: nav_down = Q_BR;
      Q_BL: if (WRAP_NAV) nav_down = Q_TL;
      Q_BR: if (WRAP_NAV) nav_down = Q_TR;
      default: ;
    endcase
  endfunction

  function automatic logic [2:0] nav_left(input logic [2:0] q);
    nav_left = q;
    case (q)
      Q_TR: nav_left = Q_TL;
      Q_BR: nav_left = Q_BL;
      Q_TL: if (WRAP_NAV) nav_left = Q_TR;
      Q_BL: if (WRAP_NAV) nav_left = Q_BR;
      default: ;
    endcase
  endfunction

  function automatic logic [2:0] nav_right(input logic [2:0] q);
    nav_right = q;
    case (q)
      Q_TL: nav_right = Q_TR;
      Q_BL: nav_right = Q_BR;
      Q_TR: if (WRAP_NAV) nav_right = Q_TL;
      Q_BR: if (WRAP_NAV) nav_right = Q_BL;
      default: ;
    endcase
  endfunction

  qsel_state_t          state_q, state_d;
  logic [2:0]           cuad_q, cuad_d;
  logic [2:0]           idx_q, idx_d;
  logic [3*SEQ_LEN-1:0] seq_q, seq_d;
  logic [2:0]           entry_arr [8];
  logic [2:0]           cur_entry;

  // Unpack the stored sequence into an 8-deep table so a 3-bit index always
  // lands in range; unused slots hold Q_NONE, which never matches.
  for (genvar k = 0; k < 8; k++) begin : g_entry
    if (k < SEQ_LEN) begin : g_used
      assign entry_arr[k] = seq_q[3*k +: 3];
    end else begin : g_unused
      assign entry_arr[k] = Q_NONE;
    end
  end

  assign cur_entry = entry_arr[idx_q];

  // Game state, quadrant, progress and stored target sequence registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cuad_q  <= Q_NONE;
      idx_q   <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      cuad_q  <= cuad_d;
      idx_q   <= idx_d;
      seq_q   <= seq_d;
    end
  end

  // Next state: start wins over everything; in NAV one action per cycle with
  // sel > up > down > left > right. seq_idx is 3 bits, so SEQ_LEN=8 wraps to 0 on WIN.
  always_comb begin
    state_d = state_q;
    cuad_d  = cuad_q;
    idx_d   = idx_q;
    seq_d   = seq_q;
    if (bus.start) begin
      seq_d   = bus.target_seq;
      idx_d   = '0;
      cuad_d  = Q_TL;
      state_d = S_NAV;
    end else if (state_q == S_NAV) begin
      if (p_sel) begin
        if (cuad_q == cur_entry) begin
          if (idx_q == 3'(SEQ_LEN - 1)) begin
            state_d = S_WIN;
            cuad_d  = Q_NONE;
            idx_d   = 3'(SEQ_LEN);
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          state_d = S_LOSE;
          cuad_d  = Q_NONE;
        end
      end else if (p_up) begin
        cuad_d = nav_up(cuad_q);
      end else if (p_down) begin
        cuad_d = nav_down(cuad_q);
      end else if (p_left) begin
        cuad_d = nav_left(cuad_q);
      end else if (p_right) begin
        cuad_d = nav_right(cuad_q);
      end
    end
  end

  assign bus.cuadrante = cuad_q;
  assign bus.seq_idx   = idx_q;
  assign bus.win       = (state_q == S_WIN);
  assign bus.lose      = (state_q == S_LOSE);
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_quadrant_selector.sv
// Directed bench for quadrant_selector with DEBOUNCE_CYCLES=4, SEQ_LEN=4.
module tb_quadrant_selector;
  import quadrant_pkg::*;

  localparam int DB  = 4;
  localparam int SL  = 4;
  localparam logic [11:0] TGT = {Q_BR, Q_BL, Q_TR, Q_TL};

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   lat;

  quadrant_selector_if #(.SEQ_LEN(SL)) bus ();

  quadrant_selector #(.DEBOUNCE_CYCLES(DB), .SEQ_LEN(SL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0: bus.btn_up    = v;
      1: bus.btn_down  = v;
      2: bus.btn_left  = v;
      3: bus.btn_right = v;
      default: bus.btn_sel = v;
    endcase
  endtask

  // Clean press: hold long enough for one debounced press, then release fully.
  task automatic press(input int which);
    @(negedge clk);
    set_btn(which, 1'b1);
    repeat (8) @(negedge clk);
    set_btn(which, 1'b0);
    repeat (8) @(negedge clk);
  endtask

  task automatic do_start(input logic [11:0] t);
    @(negedge clk);
    bus.target_seq = t;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
  endtask

  localparam int UP = 0, DN = 1, LF = 2, RT = 3, SE = 4;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_left = 1'b0;
    bus.btn_right = 1'b0; bus.btn_sel = 1'b0;
    bus.start = 1'b0; bus.target_seq = '0;
    repeat (3) @(negedge clk);
    check("rst_cuad", 32'(bus.cuadrante), 32'(Q_NONE));
    check("rst_win",  32'(bus.win), 0);
    check("rst_lose", 32'(bus.lose), 0);
    check("rst_idx",  32'(bus.seq_idx), 0);
    check("rst_state", 32'(bus.state_dbg), 32'(S_IDLE));
    rst = 1'b0;

    // IDLE ignores presses
    press(RT);
    check("idle_ignore", 32'(bus.cuadrante), 32'(Q_NONE));

    // Game to WIN: entries 001,010,011,100
    do_start(TGT);
    check("start_cuad", 32'(bus.cuadrante), 32'(Q_TL));
    check("start_state", 32'(bus.state_dbg), 32'(S_NAV));
    press(SE); check("g1_idx1", 32'(bus.seq_idx), 1);
    press(RT); check("g1_right", 32'(bus.cuadrante), 32'(Q_TR));
    press(SE); check("g1_idx2", 32'(bus.seq_idx), 2);
    press(LF); check("g1_left", 32'(bus.cuadrante), 32'(Q_TL));
    press(DN); check("g1_down", 32'(bus.cuadrante), 32'(Q_BL));
    press(SE); check("g1_idx3", 32'(bus.seq_idx), 3);
    press(UP); check("g1_up", 32'(bus.cuadrante), 32'(Q_TL));
    press(DN); press(RT); check("g1_br", 32'(bus.cuadrante), 32'(Q_BR));
    press(SE);
    check("win_flag", 32'(bus.win), 1);
    check("win_cuad", 32'(bus.cuadrante), 32'(Q_NONE));
    check("win_idx",  32'(bus.seq_idx), 4);
    press(LF);
    check("win_hold", 32'(bus.cuadrante), 32'(Q_NONE));
    check("win_hold_flag", 32'(bus.win), 1);

    // Mismatch -> LOSE
    do_start(TGT);
    check("restart_win", 32'(bus.win), 0);
    press(DN); check("g2_down", 32'(bus.cuadrante), 32'(Q_BL));
    press(SE);
    check("lose_flag", 32'(bus.lose), 1);
    check("lose_cuad", 32'(bus.cuadrante), 32'(Q_NONE));
    check("lose_idx",  32'(bus.seq_idx), 0);
    press(UP); press(SE);
    check("lose_hold", 32'(bus.lose), 1);
    check("lose_hold_cuad", 32'(bus.cuadrante), 32'(Q_NONE));
    do_start(TGT);
    check("restart_cuad", 32'(bus.cuadrante), 32'(Q_TL));
    check("restart_lose", 32'(bus.lose), 0);

    // Bouncing right: toggles every 2 cycles for 20 cycles, then held
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.btn_right = (i % 2 == 0);
      @(negedge clk);
    end
    check("bounce_nomove", 32'(bus.cuadrante), 32'(Q_TL));
    @(negedge clk);
    bus.btn_right = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (lat == 0 && bus.cuadrante == Q_TR) lat = i;
    end
    check("bounce_latency", 32'(lat), 7);
    bus.btn_right = 1'b0;
    repeat (10) @(negedge clk);
    check("bounce_one_move", 32'(bus.cuadrante), 32'(Q_TR));

    // sel and right debounced together: sel wins
    do_start(TGT);
    @(negedge clk);
    bus.btn_sel = 1'b1; bus.btn_right = 1'b1;
    repeat (8) @(negedge clk);
    bus.btn_sel = 1'b0; bus.btn_right = 1'b0;
    repeat (8) @(negedge clk);
    check("prio_idx",  32'(bus.seq_idx), 1);
    check("prio_cuad", 32'(bus.cuadrante), 32'(Q_TL));

    // Right edge behaviour
    press(RT); check("edge_first", 32'(bus.cuadrante), 32'(Q_TR));
    press(RT);
`ifdef QSEL_WRAP_NAV_EN
    check("edge_right", 32'(bus.cuadrante), 32'(Q_TL));
`else
    check("edge_right", 32'(bus.cuadrante), 32'(Q_TR));
`endif

    // Illegal stored code never matches
    do_start({Q_BR, Q_BL, Q_TR, 3'b111});
    press(SE);
    check("bad_code_lose", 32'(bus.lose), 1);

    // Asynchronous reset mid-game at seq_idx=2
    do_start(TGT);
    press(SE); press(RT); press(SE);
    check("pre_rst_idx", 32'(bus.seq_idx), 2);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_cuad", 32'(bus.cuadrante), 32'(Q_NONE));
    check("arst_idx",  32'(bus.seq_idx), 0);
    check("arst_win",  32'(bus.win), 0);
    check("arst_lose", 32'(bus.lose), 0);
    check("arst_state", 32'(bus.state_dbg), 32'(S_IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    press(SE);
    check("post_rst_state", 32'(bus.state_dbg), 32'(S_IDLE));
    check("post_rst_cuad",  32'(bus.cuadrante), 32'(Q_NONE));

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
